// File: rtl/cpu_phase_sequencer_pkg.sv
// Shared definitions for the CPU phase sequencer.
// Contents:
//   state_t       - 4-bit encoding of the sequencer phases (also driven on state_o)
//   CPI_*         - cycles per instruction class with ROM/RAM latency 1/1
//   DEFAULT_CNT_W - default width of the cycle and retired-instruction counters
//   isBusyState   - true for any phase that belongs to an instruction in flight
package cpu_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_FETCH      = 4'd1,
    ST_FETCH_WAIT = 4'd2,
    ST_DECODE     = 4'd3,
    ST_EXECUTE    = 4'd4,
    ST_MEM        = 4'd5,
    ST_MEM_WAIT   = 4'd6,
    ST_WRITEBACK  = 4'd7,
    ST_HALTED     = 4'd8
  } state_t;

  localparam int CPI_ALU       = 5;
  localparam int CPI_BRANCH    = 5;
  localparam int CPI_STORE     = 6;
  localparam int CPI_LOAD      = 7;
  localparam int DEFAULT_CNT_W = 32;

  function automatic logic isBusyState(input state_t s);
    return (s != ST_IDLE) && (s != ST_HALTED);
  endfunction

endpackage

// File: rtl/cpu_phase_sequencer_phase_wait_timer.sv
// Wait-phase timer for the CPU phase sequencer.
// A 3-bit down counter that is loaded with a latency on entry to a wait
// phase and decremented once per cycle spent in that phase.
// Ports:
//   clk          - system clock
//   reset        - asynchronous active-low reset
//   i_load       - load i_loadValue into the counter
//   i_loadValue  - number of wait cycles (1..7)
//   i_dec        - decrement while the wait phase is active
//   o_done       - high in the final cycle of the wait phase
module phase_wait_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [2:0] i_loadValue,
  input  logic       i_dec,
  output logic       o_done
);

  logic [2:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= 3'd0;
    end else if (i_load) begin
      r_count <= i_loadValue;
    end else if (i_dec && (r_count != 3'd0)) begin
      r_count <= r_count - 3'd1;
    end
  end

  // The count equals the number of wait cycles still to go including the
  // current one, so the last cycle is the one where it reads 1.
  assign o_done = (r_count <= 3'd1);

endmodule

// File: rtl/cpu_phase_sequencer.sv
// Multi-cycle phase controller for the CPU datapath.
// Steps each instruction through FETCH, FETCH_WAIT, DECODE, EXECUTE, MEM,
// MEM_WAIT and WRITEBACK, and issues one-cycle strobes for instruction
// capture, RAM access, register write and PC update. Supports free-run and
// single-step operation, a sticky HALTED state, and saturating counters.
// Ports:
//   clk, reset        - clock, asynchronous active-low reset
//   run, step         - free-run enable, single-step request (IDLE only)
//   is_* , reg_write_req, branch_taken - decode/branch inputs (DECODE..WRITEBACK)
//   ir_load, ram_read_enable, ram_write_enable, reg_write_enable,
//   pc_increment, pc_load_target - single-cycle strobes
//   halted, busy, state_o        - status
//   cycle_count, instr_retired   - saturating counters
module cpu_phase_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int ROM_LATENCY = 1,
  parameter int RAM_LATENCY = 1,
  parameter int CNT_W       = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             is_branch,
  input  logic             is_jump,
  input  logic             is_jr,
  input  logic             is_jal,
  input  logic             is_halt,
  input  logic             reg_write_req,
  input  logic             branch_taken,
  output logic             ir_load,
  output logic             ram_read_enable,
  output logic             ram_write_enable,
  output logic             reg_write_enable,
  output logic             pc_increment,
  output logic             pc_load_target,
  output logic             halted,
  output logic             busy,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_retired
);

  localparam logic [2:0]       ROM_LAT3 = 3'(ROM_LATENCY);
  localparam logic [2:0]       RAM_LAT3 = 3'(RAM_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_nextState;
  logic             w_timerLoad;
  logic             w_timerDec;
  logic [2:0]       w_timerValue;
  logic             w_timerDone;
  logic [CNT_W-1:0] r_cycleCount;
  logic [CNT_W-1:0] r_instrRetired;

  // One timer serves both wait phases; it is reloaded with the matching
  // latency from FETCH or from MEM.
  phase_wait_timer u_waitTimer (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_timerLoad),
    .i_loadValue (w_timerValue),
    .i_dec       (w_timerDec),
    .o_done      (w_timerDone)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. Zero-latency builds skip the wait phases entirely.
  // A load that is also flagged as a store is handled as a load.
  always_comb begin
    w_nextState  = r_state;
    w_timerLoad  = 1'b0;
    w_timerDec   = 1'b0;
    w_timerValue = (r_state == ST_FETCH) ? ROM_LAT3 : RAM_LAT3;
    case (r_state)
      ST_IDLE: begin
        if (run || step) w_nextState = ST_FETCH;
      end
      ST_FETCH: begin
        if (ROM_LATENCY == 0) begin
          w_nextState = ST_DECODE;
        end else begin
          w_nextState = ST_FETCH_WAIT;
          w_timerLoad = 1'b1;
        end
      end
      ST_FETCH_WAIT: begin
        w_timerDec = 1'b1;
        if (w_timerDone) w_nextState = ST_DECODE;
      end
      ST_DECODE: begin
        w_nextState = is_halt ? ST_HALTED : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        w_nextState = (is_load || is_store) ? ST_MEM : ST_WRITEBACK;
      end
      ST_MEM: begin
        if (is_load && (RAM_LATENCY != 0)) begin
          w_nextState = ST_MEM_WAIT;
          w_timerLoad = 1'b1;
        end else begin
          w_nextState = ST_WRITEBACK;
        end
      end
      ST_MEM_WAIT: begin
        w_timerDec = 1'b1;
        if (w_timerDone) w_nextState = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        w_nextState = run ? ST_FETCH : ST_IDLE;
      end
      ST_HALTED: begin
        w_nextState = ST_HALTED;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Strobes follow the registered state, so an asynchronous reset clears
  // them in the same cycle it is asserted.
  always_comb begin
    ir_load          = ((r_state == ST_FETCH_WAIT) && w_timerDone) ||
                       ((r_state == ST_FETCH) && (ROM_LATENCY == 0));
    ram_read_enable  = (r_state == ST_MEM) && is_load;
    ram_write_enable = (r_state == ST_MEM) && is_store && !is_load;
    reg_write_enable = (r_state == ST_WRITEBACK) && (reg_write_req || is_jal) && !is_store;
    pc_increment     = (r_state == ST_WRITEBACK);
    pc_load_target   = (r_state == ST_WRITEBACK) &&
                       (is_jr || is_jump || is_jal || (is_branch && branch_taken));
    halted           = (r_state == ST_HALTED);
    busy             = isBusyState(r_state);
    state_o          = r_state;
  end

  // Counters stop at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycleCount   <= '0;
      r_instrRetired <= '0;
    end else begin
      if (busy && (r_cycleCount != '1)) r_cycleCount <= r_cycleCount + CNT_ONE;
      if (pc_increment && (r_instrRetired != '1)) r_instrRetired <= r_instrRetired + CNT_ONE;
    end
  end

  assign cycle_count   = r_cycleCount;
  assign instr_retired = r_instrRetired;

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Scoreboard bench for cpu_phase_sequencer. Directed instructions push their
// hand-computed CPI and strobe profile into a queue; a monitor measures each
// instruction from FETCH to its pc_increment and compares against the queue.
module tb_cpu_phase_sequencer;

  logic clk, reset, run, step;
  logic is_load, is_store, is_branch, is_jump, is_jr, is_jal, is_halt;
  logic reg_write_req, branch_taken;
  logic ir_load, ram_read_enable, ram_write_enable, reg_write_enable;
  logic pc_increment, pc_load_target, halted, busy;
  logic [3:0]  state_o;
  logic [31:0] cycle_count, instr_retired;

  logic satIrLoad, satRamRd, satRamWr, satRegWe, satPcInc, satPcLoad, satHalted, satBusy;
  logic [3:0] satState;
  logic [3:0] satCycles, satRetired;

  typedef struct {
    int cpi;
    int regWe;
    int pcLoad;
    int ramRd;
    int ramWr;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  int   monCyc, monRd, monWr, monWe, monIr;
  logic monTrk;
  exp_t monExp;

  cpu_phase_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .step(step),
    .is_load(is_load), .is_store(is_store), .is_branch(is_branch),
    .is_jump(is_jump), .is_jr(is_jr), .is_jal(is_jal), .is_halt(is_halt),
    .reg_write_req(reg_write_req), .branch_taken(branch_taken),
    .ir_load(ir_load), .ram_read_enable(ram_read_enable),
    .ram_write_enable(ram_write_enable), .reg_write_enable(reg_write_enable),
    .pc_increment(pc_increment), .pc_load_target(pc_load_target),
    .halted(halted), .busy(busy), .state_o(state_o),
    .cycle_count(cycle_count), .instr_retired(instr_retired)
  );

  // Zero-latency, 4-bit-counter build sharing all inputs with the main DUT.
  cpu_phase_sequencer #(.ROM_LATENCY(0), .RAM_LATENCY(0), .CNT_W(4)) satDut (
    .clk(clk), .reset(reset), .run(run), .step(step),
    .is_load(is_load), .is_store(is_store), .is_branch(is_branch),
    .is_jump(is_jump), .is_jr(is_jr), .is_jal(is_jal), .is_halt(is_halt),
    .reg_write_req(reg_write_req), .branch_taken(branch_taken),
    .ir_load(satIrLoad), .ram_read_enable(satRamRd),
    .ram_write_enable(satRamWr), .reg_write_enable(satRegWe),
    .pc_increment(satPcInc), .pc_load_target(satPcLoad),
    .halted(satHalted), .busy(satBusy), .state_o(satState),
    .cycle_count(satCycles), .instr_retired(satRetired)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges outside the bounded waits
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  // Drive one instruction's decode fields, push its expected profile, and
  // wait (bounded) for its retirement.
  task automatic applyStimulus(input logic ld, input logic st, input logic br, input logic tk,
                               input logic jp, input logic jrr, input logic jl, input logic req,
                               input int cpi, input int regWe, input int pcLoad,
                               input int ramRd, input int ramWr);
    exp_t e;
    int   waited;
    is_load = ld; is_store = st; is_branch = br; branch_taken = tk;
    is_jump = jp; is_jr = jrr; is_jal = jl; reg_write_req = req; is_halt = 1'b0;
    e.cpi = cpi; e.regWe = regWe; e.pcLoad = pcLoad; e.ramRd = ramRd; e.ramWr = ramWr;
    expQ.push_back(e);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!pc_increment && waited < 40);
    if (!pc_increment) checkOutput("retire_timeout", 0, 1);
    #1;
  endtask

  // Scoreboard monitor: measures each instruction of the main DUT from its
  // FETCH cycle and compares at pc_increment.
  always @(negedge clk) begin
    if (!reset) begin
      monTrk = 1'b0;
    end else begin
      if (state_o == 4'd1) begin
        monTrk = 1'b1;
        monCyc = 0; monRd = 0; monWr = 0; monWe = 0; monIr = 0;
      end
      if (monTrk && busy) begin
        monCyc++;
        monRd += int'(ram_read_enable);
        monWr += int'(ram_write_enable);
        monWe += int'(reg_write_enable);
        monIr += int'(ir_load);
      end
      if (pc_increment) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_retire", 1, 0);
        end else begin
          monExp = expQ.pop_front();
          checkOutput("cpi", monCyc, monExp.cpi);
          checkOutput("reg_write_pulses", monWe, monExp.regWe);
          checkOutput("pc_load_target", pc_load_target, monExp.pcLoad);
          checkOutput("ram_read_pulses", monRd, monExp.ramRd);
          checkOutput("ram_write_pulses", monWr, monExp.ramWr);
          checkOutput("ir_load_pulses", monIr, 1);
        end
        monTrk = 1'b0;
      end
    end
  end

  initial begin
    int seqA[6];
    int seqE[5];
    int waited;
    int strobes;
    seqA = '{1, 2, 3, 4, 7, 1};
    seqE = '{1, 3, 4, 7, 1};
    reset = 1'b0; run = 1'b0; step = 1'b0;
    is_load = 0; is_store = 0; is_branch = 0; is_jump = 0; is_jr = 0;
    is_jal = 0; is_halt = 0; reg_write_req = 0; branch_taken = 0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_state", state_o, 0);
    checkOutput("rst_strobes", {ir_load, ram_read_enable, ram_write_enable,
                reg_write_enable, pc_increment, pc_load_target}, 0);
    checkOutput("rst_status", {halted, busy}, 0);
    checkOutput("rst_cycle_count", cycle_count, 0);
    checkOutput("rst_instr_retired", instr_retired, 0);

    // Free-run mix: ALU with state trace, then load/store/branch/jump forms
    #1 reset = 1'b1; run = 1'b1;
    fork
      applyStimulus(0,0,0,0,0,0,0,1, 5,1,0,0,0);
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        checkOutput($sformatf("alu_state_%0d", i), state_o, seqA[i]);
      end
    join
    #1;
    applyStimulus(1,0,0,0,0,0,0,1, 7,1,0,1,0);
    applyStimulus(0,1,0,0,0,0,0,1, 6,0,0,0,1);
    applyStimulus(0,0,1,1,0,0,0,0, 5,0,1,0,0);
    applyStimulus(0,0,1,0,0,0,0,0, 5,0,0,0,0);
    applyStimulus(0,0,0,0,1,0,0,0, 5,0,1,0,0);
    applyStimulus(0,0,0,0,0,1,0,0, 5,0,1,0,0);
    applyStimulus(0,0,0,0,0,0,1,0, 5,1,1,0,0);
    @(negedge clk);
    #1 run = 1'b0;
    applyStimulus(1,1,0,0,0,0,0,1, 7,0,0,1,0);
    @(negedge clk);
    checkOutput("runoff_state", state_o, 0);
    checkOutput("runoff_cycle_count", cycle_count, 50);
    checkOutput("runoff_instr_retired", instr_retired, 9);
    repeat (3) @(negedge clk);
    checkOutput("idle_cycle_count", cycle_count, 50);

    // Single-step: three step pulses, three instructions
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rst2_cycle_count", cycle_count, 0);
    #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      @(posedge clk);
      #1 step = 1'b0;
      applyStimulus(0,0,0,0,0,0,0,1, 5,1,0,0,0);
      @(negedge clk);
      checkOutput($sformatf("step_idle_%0d", i), state_o, 0);
      #1;
    end
    repeat (4) @(negedge clk);
    checkOutput("step_state", state_o, 0);
    checkOutput("step_cycle_count", cycle_count, 15);
    checkOutput("step_instr_retired", instr_retired, 3);

    // Halt: sticky, silent, counters frozen
    #1 reg_write_req = 1'b0; is_halt = 1'b1; run = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!halted && waited < 20);
    checkOutput("halt_reached", halted, 1);
    checkOutput("halt_state", state_o, 8);
    checkOutput("halt_busy", busy, 0);
    strobes = 0;
    repeat (100) begin
      @(negedge clk);
      strobes += int'(ir_load | ram_read_enable | ram_write_enable |
                      reg_write_enable | pc_increment | pc_load_target);
    end
    checkOutput("halt_strobes", strobes, 0);
    checkOutput("halt_state_held", state_o, 8);
    checkOutput("halt_cycle_count", cycle_count, 18);
    checkOutput("halt_instr_retired", instr_retired, 3);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("unhalt_state", state_o, 0);
    checkOutput("unhalt_cycle_count", cycle_count, 0);
    #1 reset = 1'b1; is_halt = 1'b0; run = 1'b0;
    @(negedge clk);
    checkOutput("unhalt_idle", {halted, state_o}, 0);

    // Reset in MEM_WAIT of a load aborts it immediately
    #1 is_load = 1'b1; reg_write_req = 1'b1; run = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (state_o != 4'd6 && waited < 20);
    checkOutput("memwait_reached", state_o, 6);
    #1 reset = 1'b0; run = 1'b0;
    #1;
    checkOutput("abort_state", state_o, 0);
    checkOutput("abort_strobes", {ram_read_enable, reg_write_enable, pc_increment, busy}, 0);
    strobes = 0;
    repeat (3) begin
      @(negedge clk);
      strobes += int'(reg_write_enable | pc_increment);
    end
    #1 reset = 1'b1;
    repeat (10) begin
      @(negedge clk);
      strobes += int'(reg_write_enable | pc_increment);
    end
    checkOutput("abort_no_write", strobes, 0);
    checkOutput("abort_idle", state_o, 0);
    checkOutput("abort_instr_retired", instr_retired, 0);

    // Saturation and zero-latency build: 16 ALU instructions
    #1 is_load = 1'b0; run = 1'b1;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          if (i == 15) begin
            @(negedge clk);
            #1 run = 1'b0;
          end
          applyStimulus(0,0,0,0,0,0,0,1, 5,1,0,0,0);
        end
      end
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          checkOutput($sformatf("lat0_state_%0d", i), satState, seqE[i]);
          if (i == 0) checkOutput("lat0_ir_load", satIrLoad, 1);
        end
      end
    join
    @(negedge clk);
    checkOutput("sat_main_state", state_o, 0);
    checkOutput("sat_main_cycle_count", cycle_count, 80);
    checkOutput("sat_main_instr_retired", instr_retired, 16);
    checkOutput("sat_cycle_count", satCycles, 15);
    checkOutput("sat_instr_retired", satRetired, 15);
    checkOutput("sat_state", satState, 0);
    checkOutput("scoreboard_empty", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_phase_sequencer.md
Name: cpu_phase_sequencer

Overview:
Multi-cycle phase controller for the CPU datapath. It steps each instruction through fetch, ROM wait, decode, execute, memory and writeback. It issues the single-cycle strobes that gate the program counter, instruction capture, register-file write and RAM read/write. It sits between the control-unit decode outputs, the branch logic and the PC/register-file/RAM enables. It also provides run/single-step debug control and cycle and retired-instruction counters.

Parameters:
ROM_LATENCY, 1, wait cycles after the ROM address is presented before the instruction is valid (0..7)
RAM_LATENCY, 1, wait cycles after a RAM read strobe before read data is valid (0..7)
CNT_W, 32, width of the cycle and retired-instruction counters

Ports:
clk  input  1  system clock (MAX10_CLK1_50 at top level)
reset  input  1  asynchronous, active-low reset
run  input  1  free-run enable
step  input  1  single-step request, sampled only in IDLE while run=0
is_load  input  1  decoded load (valid DECODE..WRITEBACK)
is_store  input  1  decoded store
is_branch  input  1  decoded conditional branch
is_jump  input  1  decoded j
is_jr  input  1  decoded jr
is_jal  input  1  decoded jal
is_halt  input  1  decoded halt
reg_write_req  input  1  decode requests register write
branch_taken  input  1  branch condition result from branch logic
ir_load  output  1  capture instruction
ram_read_enable  output  1  RAM read strobe
ram_write_enable  output  1  RAM write strobe
reg_write_enable  output  1  gated register-file write
pc_increment  output  1  PC update strobe, one pulse per retired instruction
pc_load_target  output  1  with pc_increment: PC takes the redirect address, not PC+1
halted  output  1  sequencer is in HALTED
busy  output  1  state is neither IDLE nor HALTED
state_o  output  4  current state encoding
cycle_count  output  CNT_W  busy cycles, saturating
instr_retired  output  CNT_W  retired instructions, saturating

Behaviour:
- Reset is asynchronous and active-low.
  - On reset: state=IDLE, all outputs 0, counters 0, wait timer 0.
  - Reset asserted mid-instruction aborts the instruction immediately. No write strobe is issued in or after the reset cycle.
- State encodings: IDLE=0, FETCH=1, FETCH_WAIT=2, DECODE=3, EXECUTE=4, MEM=5, MEM_WAIT=6, WRITEBACK=7, HALTED=8.
- All strobes are Moore outputs decoded from the registered state. Every strobe is exactly one cycle wide.
- IDLE: goes to FETCH if run=1, or if run=0 and step=1; otherwise stays.
- FETCH: 1 cycle. Goes to FETCH_WAIT, or straight to DECODE if ROM_LATENCY=0.
- FETCH_WAIT: lasts ROM_LATENCY cycles. ir_load is high in its final cycle (in FETCH when ROM_LATENCY=0). Then goes to DECODE.
- DECODE: 1 cycle. is_halt=1 goes to HALTED; otherwise goes to EXECUTE.
- EXECUTE: 1 cycle. is_load or is_store goes to MEM; otherwise goes to WRITEBACK.
- MEM: 1 cycle.
  - Load: ram_read_enable=1, then MEM_WAIT (or WRITEBACK if RAM_LATENCY=0).
  - Store: ram_write_enable=1, then WRITEBACK.
  - If is_load and is_store are both high, the instruction is treated as a load.
- MEM_WAIT: lasts RAM_LATENCY cycles, then goes to WRITEBACK.
- WRITEBACK: 1 cycle.
  - reg_write_enable = (reg_write_req | is_jal) & ~is_store.
  - pc_increment=1.
  - pc_load_target = jr | jump | jal | (branch & branch_taken), with priority jr > jump/jal > branch.
  - instr_retired increments.
  - Next state: FETCH if run=1, otherwise IDLE.
- HALTED: stays until reset. halted=1; no strobes; counters frozen.
- run deasserted mid-instruction: the instruction completes, then the sequencer returns to IDLE. step held high in IDLE yields one instruction per IDLE visit.
- Cycles per instruction with latency 1/1: ALU, branch and jump take 5; store takes 6; load takes 7.
- cycle_count increments on every cycle where busy=1. Both counters saturate at all-ones and do not wrap.
- Decode inputs are only sampled in DECODE..WRITEBACK. They are ignored in all other states.

Decomposition:
- Shared package cpu_seq_pkg holds:
  - the state encoding constants (4-bit);
  - CPI constants for documentation and bench checks;
  - the default CNT_W.
- One sub-module, phase_wait_timer: a 3-bit load/decrement counter with a done flag. It is instantiated once and reloaded for both FETCH_WAIT and MEM_WAIT.

Test Plan:
- Reset low, then high with run=1 and an ALU instruction (reg_write_req=1) -> state sequence 1,2,3,4,7,1. reg_write_enable and pc_increment each pulse once, on cycle 5. instr_retired=1 after WRITEBACK.
- Load with run=1 -> ram_read_enable pulses in MEM (cycle 5). reg_write_enable pulses on cycle 7. CPI 7. ram_write_enable stays 0.
- Store, then branch with branch_taken=1 -> store: ram_write_enable pulse, reg_write_enable stays 0, CPI 6. Branch: pc_load_target=1 together with pc_increment in WRITEBACK.
- run=0 with one-cycle step pulses, 3 times -> exactly 3 instructions retire. The sequencer returns to IDLE (state_o=0) after each. cycle_count=15.
- is_halt decoded -> state 8, halted=1, no further strobes for 100 cycles, counters frozen. Reset low then high -> IDLE with counters 0.
- Reset asserted during MEM_WAIT of a load -> outputs 0 in the same cycle. No reg_write_enable pulse. state_o=0.
